// File: rtl/id_stage_piped_if.sv
// Decode-stage bus: IF/ID inputs, write-back port, branch outputs and the registered ID/EXE slot.
// The master drives the instruction and write-back side; the slave is the decode stage.
interface id_stage_piped_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned STALL_CW = 16
);
  logic [31:0]         instruction;
  logic [DATA_W-1:0]   pc_next;
  logic                id_valid;
  logic                hazard_detected;
  logic                flush;
  logic                wb_en;
  logic [4:0]          wb_dest;
  logic [DATA_W-1:0]   wb_value;

  logic [4:0]          src1;
  logic [4:0]          src2;
  logic                br_taken;
  logic [DATA_W-1:0]   br_addr;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_val1;
  logic [DATA_W-1:0]   ex_val2;
  logic [DATA_W-1:0]   ex_reg2;
  logic [4:0]          ex_dest;
  logic [3:0]          ex_exe_cmd;
  logic                ex_mem_r_en;
  logic                ex_mem_w_en;
  logic                ex_wb_en;
  logic [STALL_CW-1:0] stall_count;

  modport master (
    output instruction, pc_next, id_valid, hazard_detected, flush, wb_en, wb_dest, wb_value,
    input  src1, src2, br_taken, br_addr, ex_valid, ex_val1, ex_val2, ex_reg2, ex_dest,
           ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, stall_count
  );

  modport slave (
    input  instruction, pc_next, id_valid, hazard_detected, flush, wb_en, wb_dest, wb_value,
    output src1, src2, br_taken, br_addr, ex_valid, ex_val1, ex_val2, ex_reg2, ex_dest,
           ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, stall_count
  );
endinterface

// File: rtl/id_stage_piped.sv
// Decode stage: register file with write-through, control decode, branch resolution in ID,
// a registered ID/EXE slot with bubble/flush handling and a saturating stall counter.
module id_stage_piped #(
  parameter int unsigned DATA_W   = 32,  // must be >= 16
  parameter int unsigned NUM_REGS = 32,  // must be 2..32
  parameter int unsigned BR_SHIFT = 0,
  parameter int unsigned STALL_CW = 16
) (
  input logic             clk,
  input logic             rst,
  id_stage_piped_if.slave bus
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Opcode map:
  //   1 ADD, 3 SUB, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLA, 10 SLL, 11 SRA, 12 SRL,
  //   32 ADDI, 33 SUBI, 36 LD, 37 ST, 40 BEZ, 41 BNE, 42 JMP; anything else is a NOP.
  localparam logic [5:0] OpAdd  = 6'd1;
  localparam logic [5:0] OpSub  = 6'd3;
  localparam logic [5:0] OpAnd  = 6'd5;
  localparam logic [5:0] OpOr   = 6'd6;
  localparam logic [5:0] OpNor  = 6'd7;
  localparam logic [5:0] OpXor  = 6'd8;
  localparam logic [5:0] OpSla  = 6'd9;
  localparam logic [5:0] OpSll  = 6'd10;
  localparam logic [5:0] OpSra  = 6'd11;
  localparam logic [5:0] OpSrl  = 6'd12;
  localparam logic [5:0] OpAddi = 6'd32;
  localparam logic [5:0] OpSubi = 6'd33;
  localparam logic [5:0] OpLd   = 6'd36;
  localparam logic [5:0] OpSt   = 6'd37;
  localparam logic [5:0] OpBez  = 6'd40;
  localparam logic [5:0] OpBne  = 6'd41;
  localparam logic [5:0] OpJmp  = 6'd42;

  typedef enum logic [3:0] {
    CmdAdd = 4'b0000,
    CmdSub = 4'b0010,
    CmdAnd = 4'b0100,
    CmdOr  = 4'b0101,
    CmdNor = 4'b0110,
    CmdXor = 4'b0111,
    CmdSll = 4'b1000,
    CmdSra = 4'b1001,
    CmdSrl = 4'b1010
  } exe_cmd_e;

  typedef enum logic [1:0] {BrNone, BrBez, BrBne, BrJmp} br_type_e;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [15:0] imm;

  assign op   = bus.instruction[31:26];
  assign dest = bus.instruction[25:21];
  assign src1 = bus.instruction[20:16];
  assign imm  = bus.instruction[15:0];

  // Control decode
  exe_cmd_e dec_cmd;
  br_type_e dec_br;
  logic     dec_wb;
  logic     dec_mem_r;
  logic     dec_mem_w;
  logic     dec_imm;
  logic     dec_st_bne;

  always_comb begin
    dec_cmd    = CmdAdd;
    dec_br     = BrNone;
    dec_wb     = 1'b0;
    dec_mem_r  = 1'b0;
    dec_mem_w  = 1'b0;
    dec_imm    = 1'b0;
    dec_st_bne = 1'b0;
    case (op)
      OpAdd:         dec_wb = 1'b1;
      OpSub:         begin dec_cmd = CmdSub; dec_wb = 1'b1; end
      OpAnd:         begin dec_cmd = CmdAnd; dec_wb = 1'b1; end
      OpOr:          begin dec_cmd = CmdOr;  dec_wb = 1'b1; end
      OpNor:         begin dec_cmd = CmdNor; dec_wb = 1'b1; end
      OpXor:         begin dec_cmd = CmdXor; dec_wb = 1'b1; end
      OpSla, OpSll:  begin dec_cmd = CmdSll; dec_wb = 1'b1; end
      OpSra:         begin dec_cmd = CmdSra; dec_wb = 1'b1; end
      OpSrl:         begin dec_cmd = CmdSrl; dec_wb = 1'b1; end
      OpAddi:        begin dec_wb = 1'b1; dec_imm = 1'b1; end
      OpSubi:        begin dec_cmd = CmdSub; dec_wb = 1'b1; dec_imm = 1'b1; end
      OpLd:          begin dec_wb = 1'b1; dec_mem_r = 1'b1; dec_imm = 1'b1; end
      OpSt:          begin dec_mem_w = 1'b1; dec_imm = 1'b1; dec_st_bne = 1'b1; end
      OpBez:         dec_br = BrBez;
      OpBne:         begin dec_br = BrBne; dec_st_bne = 1'b1; end
      OpJmp:         dec_br = BrJmp;
      default:       ;
    endcase
  end

  // Stores and BNE read their second operand through the dest field
  assign src2 = dec_st_bne ? dest : bus.instruction[15:11];

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic              wr_ok;
  logic              rd1_ok;
  logic              rd2_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_ok  = bus.wb_en && (bus.wb_dest != 5'd0) && (32'(bus.wb_dest) < NUM_REGS);
  assign rd1_ok = (src1 != 5'd0) && (32'(src1) < NUM_REGS);
  assign rd2_ok = (src2 != 5'd0) && (32'(src2) < NUM_REGS);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rd1_ok) rd1 = (wr_ok && bus.wb_dest == src1) ? bus.wb_value : rf_q[src1[AW-1:0]];
    if (rd2_ok) rd2 = (wr_ok && bus.wb_dest == src2) ? bus.wb_value : rf_q[src2[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wr_ok) begin
      rf_q[bus.wb_dest[AW-1:0]] <= bus.wb_value;
    end
  end

  // Operands and branch resolution
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] val2;
  logic              cond;

  assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};
  assign val2    = dec_imm ? imm_ext : rd2;

  always_comb begin
    cond = 1'b0;
    case (dec_br)
      BrBez:   cond = (rd1 == '0);
      BrBne:   cond = (rd1 != rd2);
      BrJmp:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign bus.src1     = src1;
  assign bus.src2     = src2;
  assign bus.br_taken = bus.id_valid && !bus.hazard_detected && (dec_br != BrNone) && cond;
  assign bus.br_addr  = bus.pc_next + (imm_ext << BR_SHIFT);

  // ID/EXE slot; bubbles keep their data fields at zero
  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_val1_q;
  logic [DATA_W-1:0] ex_val2_q;
  logic [DATA_W-1:0] ex_reg2_q;
  logic [4:0]        ex_dest_q;
  logic [3:0]        ex_cmd_q;
  logic              ex_mem_r_q;
  logic              ex_mem_w_q;
  logic              ex_wb_q;
  logic              bubble;

  assign bubble = bus.flush || bus.hazard_detected || !bus.id_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid_q <= 1'b0;
      ex_val1_q  <= '0;
      ex_val2_q  <= '0;
      ex_reg2_q  <= '0;
      ex_dest_q  <= '0;
      ex_cmd_q   <= '0;
      ex_mem_r_q <= 1'b0;
      ex_mem_w_q <= 1'b0;
      ex_wb_q    <= 1'b0;
    end else begin
      ex_valid_q <= 1'b1;
      ex_val1_q  <= rd1;
      ex_val2_q  <= val2;
      ex_reg2_q  <= rd2;
      ex_dest_q  <= dest;
      ex_cmd_q   <= dec_cmd;
      ex_mem_r_q <= dec_mem_r;
      ex_mem_w_q <= dec_mem_w;
      ex_wb_q    <= dec_wb;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_val1     = ex_val1_q;
  assign bus.ex_val2     = ex_val2_q;
  assign bus.ex_reg2     = ex_reg2_q;
  assign bus.ex_dest     = ex_dest_q;
  assign bus.ex_exe_cmd  = ex_cmd_q;
  assign bus.ex_mem_r_en = ex_mem_r_q;
  assign bus.ex_mem_w_en = ex_mem_w_q;
  assign bus.ex_wb_en    = ex_wb_q;

  // Stall counter: a flushed cycle is not a stall even if hazard is raised
  logic [STALL_CW-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.id_valid && bus.hazard_detected && !bus.flush && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_q;

endmodule
